mod_step_counter: RTL and testbench

// - Parametrised modulo-N up/down step counter; successor to the fixed 2-bit counter in the ChaCha20 datapath.
// - Sequences quarter-round column/diagonal selects (MODULO=4) and the round index (WIDTH=5, MODULO=20).
// - All control is synchronous except reset.
// - Adds the following to the old counter:
//   - count enable and count direction;
//   - arbitrary modulus;
//   - terminal/zero flags;
//   - wrap pulse;
//   - range-checked load.
//

---
 rtl/mod_step_counter.sv | 100 ++++++++++
 tb/tb_mod_step_counter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mod_step_counter.sv
// Modulo-N up/down step counter with clear/set/load, terminal flags, wrap and load-error pulses.
// Latency: one clock from any control input to count/wrap/load_err; at_max/at_zero decode the count register.
// Backpressure: none; every edge performs exactly one action. MOD_STEP_COUNTER_SATURATE_EN selects saturation.
module mod_step_counter #(
    parameter int WIDTH  = 2,
    parameter int MODULO = 4,
    parameter int INIT   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             set_one,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             dir,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_zero,
    output logic             wrap,
    output logic             load_err
);

    if ((WIDTH < 1) || (MODULO < 2) || (MODULO > (2 ** WIDTH))) begin : g_bad_modulo
        $error("mod_step_counter: MODULO must satisfy 2 <= MODULO <= 2**WIDTH");
    end
    if ((INIT < 0) || (INIT >= MODULO)) begin : g_bad_init
        $error("mod_step_counter: INIT must satisfy 0 <= INIT < MODULO");
    end

    // Comparisons run at WIDTH+1 bits so MODULO == 2**WIDTH is representable.
    localparam logic [WIDTH:0]   MOD_W  = (WIDTH+1)'(MODULO);
    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);

    logic [WIDTH-1:0] count_nxt;
    logic             wrap_nxt;
    logic             load_err_nxt;
    logic [WIDTH:0]   count_up;

    assign count_up = {1'b0, count} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        count_nxt    = count;
        wrap_nxt     = 1'b0;
        load_err_nxt = 1'b0;
        if (clear) begin
            count_nxt = '0;
        end else if (set_one) begin
            count_nxt = WIDTH'(1);
        end else if (load) begin
            if ({1'b0, load_value} < MOD_W) begin
                count_nxt = load_value;
            end else begin
                count_nxt    = MAX_V;
                load_err_nxt = 1'b1;
            end
        end else if (enable) begin
            if (!dir) begin
                if (count_up >= MOD_W) begin
`ifdef MOD_STEP_COUNTER_SATURATE_EN
                    count_nxt = count;
`else
                    count_nxt = '0;
`endif
                    wrap_nxt  = 1'b1;
                end else begin
                    count_nxt = count_up[WIDTH-1:0];
                end
            end else begin
                if (count == '0) begin
`ifdef MOD_STEP_COUNTER_SATURATE_EN
                    count_nxt = count;
`else
                    count_nxt = MAX_V;
`endif
                    wrap_nxt  = 1'b1;
                end else begin
                    count_nxt = count - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count    <= INIT_V;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            count    <= count_nxt;
            wrap     <= wrap_nxt;
            load_err <= load_err_nxt;
        end
    end

    assign at_max  = (count == MAX_V);
    assign at_zero = (count == '0);

endmodule

// File: tb/tb_mod_step_counter.sv
// Scoreboard bench: main counter WIDTH=5/MODULO=20, plus a WIDTH=2/MODULO=4 instance driven by enable only.
module tb_mod_step_counter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       clear, set_one, load, enable, dir, en_s;
    logic [4:0] load_value;
    logic [4:0] count;
    logic       at_max, at_zero, wrap, load_err;
    logic [1:0] s_count;
    logic       s_at_max, s_at_zero, s_wrap, s_load_err;

    always #5 clk = ~clk;

    mod_step_counter #(.WIDTH(5), .MODULO(20), .INIT(0)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .set_one(set_one), .load(load),
        .load_value(load_value), .enable(enable), .dir(dir), .count(count),
        .at_max(at_max), .at_zero(at_zero), .wrap(wrap), .load_err(load_err)
    );

    mod_step_counter #(.WIDTH(2), .MODULO(4), .INIT(0)) dut_small (
        .clk(clk), .reset_n(reset_n), .clear(1'b0), .set_one(1'b0), .load(1'b0),
        .load_value(2'b00), .enable(en_s), .dir(1'b0), .count(s_count),
        .at_max(s_at_max), .at_zero(s_at_zero), .wrap(s_wrap), .load_err(s_load_err)
    );

    typedef struct {
        logic [4:0] cnt;
        logic       wrp;
        logic       lerr;
        logic [1:0] scnt;
        logic       swrp;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   m_cnt    = 0;
    int   s_cnt    = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, push the model's prediction, then compare after the edge.
    task automatic drive(input string tag, input logic c, input logic s, input logic l,
                         input logic [4:0] lv, input logic e, input logic d, input logic es);
        exp_t x;
        int   n;
        logic w, le, sw;
        clear = c; set_one = s; load = l; load_value = lv; enable = e; dir = d; en_s = es;
        n = m_cnt; w = 1'b0; le = 1'b0; sw = 1'b0;
        if (c) n = 0;
        else if (s) n = 1;
        else if (l) begin
            if (lv >= 20) begin n = 19; le = 1'b1; end
            else n = lv;
        end else if (e) begin
            if (!d) begin
                if (m_cnt == 19) begin
                    w = 1'b1;
`ifndef MOD_STEP_COUNTER_SATURATE_EN
                    n = 0;
`endif
                end else n = m_cnt + 1;
            end else begin
                if (m_cnt == 0) begin
                    w = 1'b1;
`ifndef MOD_STEP_COUNTER_SATURATE_EN
                    n = 19;
`endif
                end else n = m_cnt - 1;
            end
        end
        m_cnt = n;
        if (es) begin
            if (s_cnt == 3) begin
                sw = 1'b1;
`ifndef MOD_STEP_COUNTER_SATURATE_EN
                s_cnt = 0;
`endif
            end else s_cnt = s_cnt + 1;
        end
        x.cnt = 5'(n); x.wrp = w; x.lerr = le; x.scnt = 2'(s_cnt); x.swrp = sw;
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, " scoreboard_empty"}, 1, 0);
        end else begin
            x = sb.pop_front();
            chk({tag, " count"},    32'(count),    32'(x.cnt));
            chk({tag, " wrap"},     32'(wrap),     32'(x.wrp));
            chk({tag, " load_err"}, 32'(load_err), 32'(x.lerr));
            chk({tag, " at_max"},   32'(at_max),   32'(x.cnt == 5'd19));
            chk({tag, " at_zero"},  32'(at_zero),  32'(x.cnt == 5'd0));
            chk({tag, " s_count"},  32'(s_count),  32'(x.scnt));
            chk({tag, " s_wrap"},   32'(s_wrap),   32'(x.swrp));
            chk({tag, " s_at_max"}, 32'(s_at_max), 32'(x.scnt == 2'd3));
        end
    endtask

    task automatic idle_inputs();
        clear = 0; set_one = 0; load = 0; load_value = 0; enable = 0; dir = 0; en_s = 0;
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        #12;
        chk("reset count",    32'(count),    0);
        chk("reset wrap",     32'(wrap),     0);
        chk("reset load_err", 32'(load_err), 0);
        chk("reset at_zero",  32'(at_zero),  1);
        chk("reset at_max",   32'(at_max),   0);
        chk("reset s_count",  32'(s_count),  0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // T1: asynchronous reset mid-count at 13
        drive("t1_load", 0, 0, 1, 5'd12, 0, 0, 1);
        drive("t1_up",   0, 0, 0, 5'd0,  1, 0, 1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("t1 async count",    32'(count),    0);
        chk("t1 async wrap",     32'(wrap),     0);
        chk("t1 async load_err", 32'(load_err), 0);
        chk("t1 async at_zero",  32'(at_zero),  1);
        chk("t1 async s_count",  32'(s_count),  0);
        m_cnt = 0;
        s_cnt = 0;
        idle_inputs();
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t1 after release count", 32'(count), 0);

        // T2: 20 up steps wrap back to 0; small instance shows 0,1,2,3,0 pattern
        for (int i = 0; i < 20; i++) drive("t2_up", 0, 0, 0, 5'd0, 1, 0, 1);
        drive("t2_hold", 0, 0, 0, 5'd0, 0, 0, 0);

        // T3: down from 1 crosses zero
        drive("t3_load", 0, 0, 1, 5'd1, 0, 0, 0);
        drive("t3_dn",   0, 0, 0, 5'd0, 1, 1, 0);
        drive("t3_dn",   0, 0, 0, 5'd0, 1, 1, 0);

        // T4: in-range and out-of-range loads
        drive("t4_load7",  0, 0, 1, 5'd7,  0, 0, 0);
        drive("t4_load25", 0, 0, 1, 5'd25, 0, 0, 0);
        drive("t4_hold",   0, 0, 0, 5'd0,  0, 0, 0);
        drive("t4_load20", 0, 0, 1, 5'd20, 0, 0, 0);
        drive("t4_load19", 0, 0, 1, 5'd19, 0, 0, 0);

        // T5: priority clear > set_one > load > enable
        drive("t5_all",    1, 1, 1, 5'd9, 1, 0, 0);
        drive("t5_noclr",  0, 1, 1, 5'd9, 1, 0, 0);
        drive("t5_noset",  0, 0, 1, 5'd9, 1, 0, 0);
        drive("t5_enonly", 0, 0, 0, 5'd9, 1, 1, 0);

        // T6: approach the top from 18 and the bottom from 0
        drive("t6_load18", 0, 0, 1, 5'd18, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive("t6_up", 0, 0, 0, 5'd0, 1, 0, 0);
        drive("t6_load0", 0, 0, 1, 5'd0, 0, 0, 0);
        drive("t6_dn",    0, 0, 0, 5'd0, 1, 1, 0);

        // Random mix of all controls
        for (int i = 0; i < 300; i++) begin
            drive("rand",
                  $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 7) == 0,  5'($urandom_range(0, 31)),
                  $urandom_range(0, 3) != 0,  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
